// File: rtl/prog_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_counter_pkg
//  Purpose  : Shared types and constants for the programmable counter.
//             cnt_mode_e selects the terminal-count behaviour. DIR_UP and
//             DIR_DOWN are the two encodings of the direction input.
//  Revision : 1.0  initial release
// ============================================================================
package prog_counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } cnt_mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : prog_counter_pkg
`default_nettype wire

// File: rtl/prog_counter_cnt_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_prescaler
//  Purpose  : Tick generator. It produces one advance tick for every
//             div_i+1 enabled cycles.
//  Ports    : clk    - clock
//             rst    - synchronous active-high reset (clears count)
//             clr_i  - synchronous clear (counter load)
//             en_i   - enable; the count holds while this is low
//             div_i  - divisor minus one (0 = tick every enabled cycle)
//             tick_o - advance qualifier for the current cycle
//  Revision : 1.0  initial release
// ============================================================================
module cnt_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic               w_hit;

  // The tick is combinational from the count register. It only feeds the
  // counter's next-state logic and never reaches a module output directly.
  assign w_hit  = (presc_q == div_i);
  assign tick_o = en_i & w_hit;

  always_comb begin
    presc_d = presc_q;
    if (clr_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = w_hit ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule : cnt_prescaler
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : prog_counter
//  Purpose  : Programmable up/down counter with step, limit, and
//             WRAP / SAT / ONESHOT terminal behaviour. It provides a one-cycle
//             terminal-count pulse and a sticky done flag.
//  Ports    : clk, rst (sync, active-high), en_i, load_i, load_val_i, dir_i,
//             step_i, cnt_max_i, mode_i, [presc_div_i], cnt_o, tc_o, done_o
//  Config   : PROG_COUNTER_PRESCALE_EN adds presc_div_i. When this macro is
//             defined, an advance happens once per presc_div_i+1 enabled
//             cycles.
//  Revision : 1.0  initial release
// ============================================================================
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned W       = 48,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [W-1:0]       load_val_i,
  input  logic               dir_i,
  input  logic [W-1:0]       step_i,
  input  logic [W-1:0]       cnt_max_i,
  input  logic [1:0]         mode_i,
`ifdef PROG_COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div_i,
`endif
  output logic [W-1:0]       cnt_o,
  output logic               tc_o,
  output logic               done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         done_q, done_d;

  logic [W:0]   w_sum;
  logic [W-1:0] w_up_next;
  logic [W-1:0] w_dn_next;
  logic [W-1:0] w_adv_next;
  logic [W-1:0] w_lim;
  logic         w_down;
  logic         w_term;
  logic         w_land;
  logic         w_tick;
  logic         w_adv;
  logic         w_sat_like;
  logic         w_oneshot;

  // Prescaler. A done counter is stopped, so the prescaler is frozen with it.
`ifdef PROG_COUNTER_PRESCALE_EN
  cnt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load_i),
    .en_i   (en_i & ~done_q),
    .div_i  (presc_div_i),
    .tick_o (w_tick)
  );
`else
  logic w_unused_presc;
  assign w_unused_presc = ^PRESC_W;
  assign w_tick         = 1'b1;
`endif

  // Mode code 3 is not decoded, so it falls through to WRAP behaviour.
  assign w_sat_like = (mode_i == SAT) || (mode_i == ONESHOT);
  assign w_oneshot  = (mode_i == ONESHOT);
  assign w_down     = (dir_i == DIR_DOWN);

  // The up sum uses one extra bit so a carry out of W bits still clamps
  // to cnt_max instead of wrapping to a small value.
  assign w_sum      = {1'b0, cnt_q} + {1'b0, step_i};
  assign w_up_next  = (w_sum > {1'b0, cnt_max_i}) ? cnt_max_i : w_sum[W-1:0];
  assign w_dn_next  = (step_i > cnt_q) ? '0 : (cnt_q - step_i);
  assign w_adv_next = w_down ? w_dn_next : w_up_next;
  assign w_lim      = w_down ? '0 : cnt_max_i;

  // A count above cnt_max while counting up is a terminal event, not overflow.
  assign w_term     = w_down ? (cnt_q == '0) : (cnt_q >= cnt_max_i);
  assign w_land     = (w_adv_next == w_lim);
  assign w_adv      = en_i & ~done_q & w_tick;

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      done_d = 1'b0;
    end else if (w_adv) begin
      if (w_term) begin
        if (w_sat_like) begin
          // Already at the limit: hold quietly. If the count is beyond the
          // limit (cnt_max lowered at run time), pull it back onto the limit,
          // and treat that as the first arrival.
          cnt_d  = w_lim;
          tc_d   = (cnt_q != w_lim);
          done_d = w_oneshot & (cnt_q != w_lim);
        end else begin
          cnt_d = w_down ? cnt_max_i : '0;
          tc_d  = 1'b1;
        end
      end else begin
        cnt_d = w_adv_next;
        // SAT and ONESHOT pulse on the edge that first lands on the limit.
        if (w_sat_like && w_land) begin
          tc_d   = 1'b1;
          done_d = w_oneshot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign done_o = done_q;

endmodule : prog_counter
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_counter
//  Purpose  : Directed self-checking bench for prog_counter (W=8). The
//             expected values are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         dir;
  logic [W-1:0] step;
  logic [W-1:0] cnt_max;
  logic [1:0]   mode;
  logic [7:0]   presc_div;
  logic [W-1:0] cnt;
  logic         tc;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_counter #(
    .W       (W),
    .PRESC_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .load_i      (load),
    .load_val_i  (load_val),
    .dir_i       (dir),
    .step_i      (step),
    .cnt_max_i   (cnt_max),
    .mode_i      (mode),
`ifdef PROG_COUNTER_PRESCALE_EN
    .presc_div_i (presc_div),
`endif
    .cnt_o       (cnt),
    .tc_o        (tc),
    .done_o      (done)
  );

  task automatic chk(input string tag, input logic [W-1:0] e_cnt,
                     input logic e_tc, input logic e_done);
    n_vec++;
    assert (cnt === e_cnt && tc === e_tc && done === e_done)
    else begin
      n_err++;
      $error("FAIL %s: observed cnt=%0d tc=%b done=%b expected cnt=%0d tc=%b done=%b",
             tag, cnt, tc, done, e_cnt, e_tc, e_done);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic edge_chk(input string tag, input logic [W-1:0] e_cnt,
                          input logic e_tc, input logic e_done);
    @(posedge clk);
    #1;
    chk(tag, e_cnt, e_tc, e_done);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; dir = 1'b0;
    step = '0; cnt_max = '0; mode = 2'd0; presc_div = 8'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset", 8'd0, 1'b0, 1'b0);

    // WRAP up, step 2, max 16: 2..16 then 0 with tc
    mode = 2'd0; dir = 1'b0; step = 8'd2; cnt_max = 8'd16; en = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) edge_chk("wrap2_up", 8'(2*i), 1'b0, 1'b0);
    edge_chk("wrap2_tc", 8'd0, 1'b1, 1'b0);
    edge_chk("wrap2_after", 8'd2, 1'b0, 1'b0);

    // load with en high: load wins, no advance
    load = 1'b1; load_val = 8'd0; step = 8'd3; cnt_max = 8'd10;
    edge_chk("load_en", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("wrap3_a", 8'd3, 1'b0, 1'b0);
    edge_chk("wrap3_b", 8'd6, 1'b0, 1'b0);
    edge_chk("wrap3_c", 8'd9, 1'b0, 1'b0);
    edge_chk("wrap3_clamp", 8'd10, 1'b0, 1'b0);
    edge_chk("wrap3_tc", 8'd0, 1'b1, 1'b0);
    edge_chk("wrap3_after", 8'd3, 1'b0, 1'b0);

    // SAT down from 5, step 2: 3,1,0(tc),0,0
    mode = 2'd1; dir = 1'b1; step = 8'd2; load = 1'b1; load_val = 8'd5;
    edge_chk("sat_load", 8'd5, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("sat_dn_a", 8'd3, 1'b0, 1'b0);
    edge_chk("sat_dn_b", 8'd1, 1'b0, 1'b0);
    edge_chk("sat_dn_tc", 8'd0, 1'b1, 1'b0);
    edge_chk("sat_hold1", 8'd0, 1'b0, 1'b0);
    edge_chk("sat_hold2", 8'd0, 1'b0, 1'b0);

    // ONESHOT up, step 4, max 8
    mode = 2'd2; dir = 1'b0; step = 8'd4; cnt_max = 8'd8;
    load = 1'b1; load_val = 8'd0;
    edge_chk("os_load", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("os_a", 8'd4, 1'b0, 1'b0);
    edge_chk("os_done", 8'd8, 1'b1, 1'b1);
    edge_chk("os_hold1", 8'd8, 1'b0, 1'b1);
    edge_chk("os_hold2", 8'd8, 1'b0, 1'b1);
    load = 1'b1; load_val = 8'd0;
    edge_chk("os_reload", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("os_resume", 8'd4, 1'b0, 1'b0);

    // rst + load + en together: rst wins
    rst = 1'b1; load = 1'b1; load_val = 8'd99;
    edge_chk("rst_over_load", 8'd0, 1'b0, 1'b0);
    rst = 1'b0; load_val = 8'd77; mode = 2'd0; step = 8'd1; cnt_max = 8'd200;
    edge_chk("load_no_adv", 8'd77, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("adv_after_load", 8'd78, 1'b0, 1'b0);

    // en low holds
    en = 1'b0;
    edge_chk("en_low_hold", 8'd78, 1'b0, 1'b0);

    // SAT up clamp to max 80 with step 5
    en = 1'b1; mode = 2'd1; cnt_max = 8'd80; step = 8'd5;
    edge_chk("sat_up_clamp", 8'd80, 1'b1, 1'b0);
    edge_chk("sat_up_hold", 8'd80, 1'b0, 1'b0);

    // WRAP down, step 30: 50,20,0(clamp),80(tc)
    mode = 2'd0; dir = 1'b1; step = 8'd30;
    edge_chk("wrap_dn_a", 8'd50, 1'b0, 1'b0);
    edge_chk("wrap_dn_b", 8'd20, 1'b0, 1'b0);
    edge_chk("wrap_dn_clamp0", 8'd0, 1'b0, 1'b0);
    edge_chk("wrap_dn_reload", 8'd80, 1'b1, 1'b0);

    // mode 3 acts as WRAP; cnt above max counting up is terminal
    mode = 2'd3; dir = 1'b0; load = 1'b1; load_val = 8'd100;
    edge_chk("above_load", 8'd100, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("above_max_term", 8'd0, 1'b1, 1'b0);

    // step 0 holds without tc
    step = 8'd0;
    edge_chk("step0_hold", 8'd0, 1'b0, 1'b0);

    // carry out of W bits clamps to max instead of wrapping
    mode = 2'd0; cnt_max = 8'd250; step = 8'd200; load = 1'b1; load_val = 8'd100;
    edge_chk("carry_load", 8'd100, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("carry_clamp", 8'd250, 1'b0, 1'b0);

`ifdef PROG_COUNTER_PRESCALE_EN
    // presc_div 3: advance every 4th enabled cycle
    presc_div = 8'd3; step = 8'd1; cnt_max = 8'd200; mode = 2'd0; dir = 1'b0;
    load = 1'b1; load_val = 8'd0;
    edge_chk("presc_load", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    edge_chk("presc_c1", 8'd0, 1'b0, 1'b0);
    edge_chk("presc_c2", 8'd0, 1'b0, 1'b0);
    edge_chk("presc_c3", 8'd0, 1'b0, 1'b0);
    edge_chk("presc_tick1", 8'd1, 1'b0, 1'b0);
    edge_chk("presc_d1", 8'd1, 1'b0, 1'b0);
    en = 1'b0;
    edge_chk("presc_off1", 8'd1, 1'b0, 1'b0);
    edge_chk("presc_off2", 8'd1, 1'b0, 1'b0);
    en = 1'b1;
    edge_chk("presc_d2", 8'd1, 1'b0, 1'b0);
    edge_chk("presc_d3", 8'd1, 1'b0, 1'b0);
    edge_chk("presc_tick2", 8'd2, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_prog_counter
`default_nettype wire

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter W, default 48, counter/step/limit width in bits (W >= 2).
REQ-002 Parameter PRESC_W, default 8, prescaler divisor width; used only when the prescaler is compiled in (REQ-026).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; hold when low.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  W  value written to cnt on load.
REQ-008 dir  input  1  0 = count up, 1 = count down.
REQ-009 step  input  W  increment/decrement per advance; 0 = hold value.
REQ-010 cnt_max  input  W  terminal value (up) / reload value (down).
REQ-011 mode  input  2  cnt_mode_e: WRAP, SAT, ONESHOT; code 3 behaves as WRAP.
REQ-012 cnt  output  W  registered count.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 done  output  1  registered sticky flag, ONESHOT only.

Function
REQ-015 Priority per edge SHALL be rst > load > advance > hold; advance = en high and no ONESHOT stop (plus prescaler tick if compiled in).
REQ-016 load SHALL set cnt = load_val, tc = 0, done = 0, regardless of en or mode.
REQ-017 Up advance: cnt >= cnt_max -> terminal event; else next = cnt + step computed in W+1 bits, clamped to cnt_max if it exceeds it (limit always hit exactly, no carry lost).
REQ-018 Down advance: cnt == 0 -> terminal event; else next = cnt - step, clamped to 0 if step > cnt.
REQ-019 WRAP terminal event: up -> cnt = 0; down -> cnt = cnt_max; tc = 1 for that cycle.
REQ-020 SAT: cnt holds at the limit (cnt_max up, 0 down); tc pulses once, on the edge cnt first lands on the limit; no further tc while holding.
REQ-021 ONESHOT: as SAT, plus done = 1 on the same edge as tc; while done = 1 cnt holds and en is ignored until load or rst.
REQ-022 tc SHALL be 0 on every edge without a qualifying event (including en low, load, hold).
REQ-023 Latency: cnt, tc, done change on the edge that samples the causing inputs (one cycle); no combinational input-to-output path.
REQ-024 Runtime changes to dir, step, cnt_max, mode take effect on the next advance; cnt > cnt_max when counting up is a terminal event (REQ-017), never an overflow.

Reset
REQ-025 rst SHALL force cnt = 0, tc = 0, done = 0 and clear the prescaler count, mid-operation included; rst overrides simultaneous load.

Configuration
REQ-026 Macro PROG_COUNTER_PRESCALE_EN defined: adds input presc_div (PRESC_W bits); advance occurs once per presc_div+1 enabled cycles; the prescaler count is cleared by rst and load and holds while en is low; presc_div = 0 gives an advance on every enabled cycle.
REQ-027 Macro undefined: no presc_div port, no prescaler logic; advance = en and not ONESHOT stop.

Structure
REQ-028 Package prog_counter_pkg SHALL hold typedef enum cnt_mode_e (WRAP=0, SAT=1, ONESHOT=2) and localparams DIR_UP=0, DIR_DOWN=1.
REQ-029 One sub-module, cnt_prescaler (tick generator), instantiated only under PROG_COUNTER_PRESCALE_EN.

Verification
REQ-030 W=8, WRAP, up, step=2, cnt_max=16, en=1 from reset -> cnt 0,2,...,16,0; tc high only on the 16->0 edge.
REQ-031 WRAP up, step=3, cnt_max=10 -> 0,3,6,9,10,0; tc on the 10->0 edge only.
REQ-032 SAT down, load_val=5, step=2 -> 5,3,1,0,0,0; tc exactly once (1->0).
REQ-033 ONESHOT up, step=4, cnt_max=8 -> 0,4,8 with tc and done on the same edge; en held high -> cnt stays 8; load=1, load_val=0 -> done=0, counting resumes.
REQ-034 rst, load and en asserted together mid-count -> cnt=0, tc=0, done=0 next cycle; load+en without rst -> cnt=load_val, no advance that cycle.
REQ-035 With PROG_COUNTER_PRESCALE_EN, presc_div=3, step=1, en=1 -> cnt increments every 4th cycle; en low for 2 cycles stretches the interval by exactly 2 cycles.
